// File: rtl/vram_scanout_reader.sv
// Sweeps gpu_address over one IMG_W x IMG_H frame per start and streams returned pixels with sof/eol/eof markers;
// first pixel RD_LAT+1 cycles after start, then 1/cycle, stalls hold on !pix_ready. Define FRAME_CHECKSUM_EN for a 16-bit frame checksum.
module vram_scanout_reader #(
    parameter int                IMG_W     = 300,
    parameter int                IMG_H     = 300,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] gpu_address,
    input  logic [DATA_W-1:0] vram_out,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              done
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int DEPTH = RD_LAT + 2;
    localparam int IDX_W = $clog2(NPIX + 1);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   gpu_address_q;
    logic [IDX_W-1:0]    issue_idx_q;
    logic                busy_q;
    logic                done_q;

    logic [RD_LAT-1:0]   tag_q;
    logic [RD_LAT-1:0]   tag_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [COL_W-1:0]    col_q;
    logic [ROW_W-1:0]    row_q;

    logic [CNT_W-1:0]    inflight;
    logic                credit_ok;
    logic                start_acc;
    logic                issue;
    logic                last_issue;
    logic                fifo_wr;
    logic                hs;
    logic                last_col;
    logic                last_px;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Reads outstanding in the VRAM pipe plus pixels parked in the FIFO never exceed DEPTH,
    // so every returning read has a free slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(tag_q[i]);
        end
    end

    assign credit_ok  = ({1'b0, inflight} + {1'b0, cnt_q}) < (CNT_W + 1)'(DEPTH);
    assign start_acc  = (state_q == S_IDLE) && start;
    assign issue      = start_acc || ((state_q == S_RUN) && credit_ok);
    assign last_issue = (issue_idx_q == IDX_W'(NPIX - 1));
    assign fifo_wr    = tag_q[RD_LAT-1];
    assign hs         = pix_valid && pix_ready;
    assign last_col   = (col_q == COL_W'(IMG_W - 1));
    assign last_px    = last_col && (row_q == ROW_W'(IMG_H - 1));

    always_comb begin
        tag_d    = '0;
        tag_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (fifo_wr && !hs) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!fifo_wr && hs) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            gpu_address_q <= BASE_ADDR;
            issue_idx_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (issue) begin
                gpu_address_q <= BASE_ADDR + ADDR_W'(issue_idx_q);
                issue_idx_q   <= issue_idx_q + IDX_W'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= (NPIX == 1) ? S_DRAIN : S_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (issue && last_issue) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (hs && last_px) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    issue_idx_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tag_q <= tag_d;
            cnt_q <= cnt_d;
            if (fifo_wr) begin
                mem_q[wr_ptr_q] <= vram_out;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (hs) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                if (last_col) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else if (start_acc) begin
            checksum_q <= '0;
        end else if (hs) begin
            checksum_q <= checksum_q + 16'(pix_data);
        end
    end

    assign checksum = checksum_q;
`endif

    // Data and markers are gated by valid so nothing stale leaks out after reset.
    assign pix_valid   = (cnt_q != '0);
    assign pix_data    = pix_valid ? mem_q[rd_ptr_q] : '0;
    assign pix_sof     = pix_valid && (col_q == '0) && (row_q == '0);
    assign pix_eol     = pix_valid && last_col;
    assign pix_eof     = pix_valid && last_px;
    assign gpu_address = gpu_address_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_vram_scanout_reader.sv
// Directed bench: two 4x3 instances (RD_LAT=1 base 0, RD_LAT=3 base 1000) fed by VRAM models returning mem[a]=a mod 256.
module tb_vram_scanout_reader;

    logic        clk;
    logic        rst_n;
    logic        start_v;
    logic        rdy_v;
    int          sel;
    int          n_tests;
    int          n_fail;

    logic        start_a, start_b;
    logic [31:0] a_addr, b_addr;
    logic [7:0]  vram_a, vram_b, b_d1, b_d2;
    logic [7:0]  a_dat, b_dat;
    logic        a_vld, a_sof, a_eol, a_eof, a_busy, a_done;
    logic        b_vld, b_sof, b_eol, b_eof, b_busy, b_done;
`ifdef FRAME_CHECKSUM_EN
    logic [15:0] a_cks, b_cks;
`endif

    logic [31:0] c_addr;
    logic [7:0]  c_dat;
    logic        c_vld, c_sof, c_eol, c_eof, c_busy, c_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign start_a = start_v && (sel == 0);
    assign start_b = start_v && (sel == 1);

    // RD_LAT=1: data for the address set at edge e is sampled at edge e+1.
    assign vram_a = a_addr[7:0];
    // RD_LAT=3: two extra register stages.
    always @(posedge clk) begin
        b_d1 <= b_addr[7:0];
        b_d2 <= b_d1;
    end
    assign vram_b = b_d2;

    assign c_addr = (sel == 1) ? b_addr : a_addr;
    assign c_dat  = (sel == 1) ? b_dat  : a_dat;
    assign c_vld  = (sel == 1) ? b_vld  : a_vld;
    assign c_sof  = (sel == 1) ? b_sof  : a_sof;
    assign c_eol  = (sel == 1) ? b_eol  : a_eol;
    assign c_eof  = (sel == 1) ? b_eof  : a_eof;
    assign c_busy = (sel == 1) ? b_busy : a_busy;
    assign c_done = (sel == 1) ? b_done : a_done;

    vram_scanout_reader #(
        .IMG_W(4), .IMG_H(3), .ADDR_W(32), .DATA_W(8), .BASE_ADDR(32'd0), .RD_LAT(1)
    ) u_dut_a (
        .clk(clk), .reset(rst_n), .start(start_a), .gpu_address(a_addr), .vram_out(vram_a),
        .pix_data(a_dat), .pix_valid(a_vld), .pix_ready(rdy_v), .pix_sof(a_sof),
        .pix_eol(a_eol), .pix_eof(a_eof), .busy(a_busy), .done(a_done)
`ifdef FRAME_CHECKSUM_EN
        , .checksum(a_cks)
`endif
    );

    vram_scanout_reader #(
        .IMG_W(4), .IMG_H(3), .ADDR_W(32), .DATA_W(8), .BASE_ADDR(32'd1000), .RD_LAT(3)
    ) u_dut_b (
        .clk(clk), .reset(rst_n), .start(start_b), .gpu_address(b_addr), .vram_out(vram_b),
        .pix_data(b_dat), .pix_valid(b_vld), .pix_ready(rdy_v), .pix_sof(b_sof),
        .pix_eol(b_eol), .pix_eof(b_eof), .busy(b_busy), .done(b_done)
`ifdef FRAME_CHECKSUM_EN
        , .checksum(b_cks)
`endif
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // d selects the instance; bp toggles pix_ready 1,0,0,1; inj pulses start in RUN and in
    // the done cycle; abort_at>0 asserts reset right after that many handshakes.
    task automatic run_frame(input int d, input bit bp, input bit inj, input int abort_at);
        int         lat, cyc, npix, first, depth;
        longint     base;
        bit         got_done, prev_stall;
        logic [7:0] prev_dat;
        logic [3:0] pat;
        lat   = (d == 1) ? 3 : 1;
        base  = (d == 1) ? 1000 : 0;
        depth = lat + 2;
        pat   = 4'b1001;
        sel   = d;
        rdy_v = 1'b1;
        start_v = 1'b1;
        @(posedge clk); #1;
        start_v = 1'b0;
        cyc = 1; npix = 0; first = -1; got_done = 0; prev_stall = 0; prev_dat = '0;
        while (!got_done && cyc < 200) begin
            rdy_v   = bp ? pat[cyc % 4] : 1'b1;
            start_v = inj && (cyc == 5);
            @(negedge clk);
            if (c_vld && first < 0) begin
                first = cyc;
                if (!bp) chk("first_valid_cycle", cyc, lat + 1);
            end
            if (prev_stall) chk("stall_hold", c_dat, prev_dat);
            if (!c_vld) chk("markers_idle", {c_sof, c_eol, c_eof}, 0);
            if (c_busy) chk("issue_ahead", ((longint'(c_addr) - base + 1 - npix) <= depth), 1);
            if (c_vld && rdy_v) begin
                chk("pix_data", c_dat, (base + npix) & 255);
                chk("pix_sof", c_sof, npix == 0);
                chk("pix_eol", c_eol, (npix % 4) == 3);
                chk("pix_eof", c_eof, npix == 11);
                if (!bp) chk("pix_cycle", cyc, lat + 1 + npix);
                npix++;
                if (npix == abort_at) begin
                    #1 rst_n = 1'b0;
                    #1;
                    chk("rst_valid", c_vld, 0);
                    chk("rst_data", c_dat, 0);
                    chk("rst_markers", {c_sof, c_eol, c_eof}, 0);
                    chk("rst_busy", c_busy, 0);
                    chk("rst_done", c_done, 0);
                    chk("rst_addr", c_addr, base);
                    #20 rst_n = 1'b1;
                    start_v = 1'b0;
                    @(posedge clk); #1;
                    return;
                end
            end
            if (c_done) begin
                got_done = 1;
                chk("done_npix", npix, 12);
                if (!bp) chk("done_cycle", cyc, lat + 13);
                if (inj) start_v = 1'b1;
            end
            chk("busy", c_busy, !got_done);
            prev_stall = c_vld && !rdy_v;
            prev_dat   = c_dat;
            @(posedge clk); #1;
            cyc++;
        end
        start_v = 1'b0;
        if (!got_done) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("post_done", c_done, 0);
        chk("post_valid", c_vld, 0);
        chk("post_busy", c_busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sel     = 0;
        start_v = 1'b0;
        rdy_v   = 1'b1;
        rst_n   = 1'b0;
        #12;
        chk("reset_valid", a_vld, 0);
        chk("reset_data", a_dat, 0);
        chk("reset_markers", {a_sof, a_eol, a_eof}, 0);
        chk("reset_busy", a_busy, 0);
        chk("reset_done", a_done, 0);
        chk("reset_addr_a", a_addr, 0);
        chk("reset_addr_b", b_addr, 1000);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(0, 1'b0, 1'b0, -1);
        run_frame(0, 1'b1, 1'b0, -1);
        run_frame(1, 1'b0, 1'b0, -1);
        run_frame(0, 1'b0, 1'b0, 6);
        run_frame(0, 1'b0, 1'b0, -1);
        run_frame(0, 1'b0, 1'b1, -1);
        run_frame(0, 1'b0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
